uart_tx_buf: RTL
================

# uart_tx_buf

Memory-mapped UART transmitter sitting on the rib bus directly downstream of the student-ID sequencer and of ordinary store instructions. Byte writes to the UART data address are pushed into a small FIFO and serialized 8N1, LSB first, on a single TX pin. Full/busy status is exported to the core so the sequencer can hold off while the buffer drains.

## Interface
- `CLK_HZ`, 50_000_000: core clock frequency.
- `BAUD`, 115200: default baud rate; reset divisor = `CLK_HZ/BAUD`.
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, at least 2.
- `BASE_ADDR`, `UART_ADDR`: bus base of the register window.

- `clk`  in  1: core clock; all state on rising edge.
- `rst`  in  1: synchronous, active-low reset (`RstEnable` = 0).
- `we_i`  in  1: bus write strobe.
- `waddr_i`  in  32: write address.
- `wdata_i`  in  32: write data; only [7:0] used for TX data.
- `raddr_i`  in  32: read address.
- `rdata_o`  out  32: combinational read data.
- `full_o`  out  1: FIFO full, combinational from count.
- `busy_o`  out  1: FIFO non-empty or frame in progress.
- `tx_o`  out  1: serial line, registered, idle high.

## Operation
- Register map, offsets from `BASE_ADDR`:
  - 0x0 TXDATA (write only): pushes `wdata_i[7:0]`; reads return 0.
  - 0x4 STATUS (read): bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky), bits[8:4] FIFO count, all other bits 0. Writing 1 to bit3 clears overflow.
  - 0x8 DIV (r/w): 16-bit baud divisor in [15:0].
- Unmapped addresses: writes are ignored and reads return 0.
- Push rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, overflow is set, and count is unchanged.
- DIV semantics:
  - Written values below 2 are stored as 2.
  - A new value takes effect at the next frame start; the frame in progress keeps the divisor latched at its start.
- FSM states:
  - IDLE: `tx_o`=1. If count≠0, pop into an 8-bit shift register, latch DIV, and go to START.
  - START: `tx_o`=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx_o`=shift[0] for DIV cycles per bit, then shift right. After bit 7, go to STOP.
  - STOP: `tx_o`=1 for DIV cycles. Then, if count≠0, pop and go directly to START (back-to-back); otherwise go to IDLE.
- Baud counter:
  - Runs 0..DIV-1 and clears on every state change.
  - Frame length is exactly 10×DIV cycles.

## Timing
- Reset values: `tx_o`=1, `full_o`=0, `busy_o`=0, `rdata_o`=0 (with `raddr_i` pointing to TXDATA). Internally, FIFO empty, overflow=0, DIV=`CLK_HZ/BAUD`, FSM in IDLE.
- Write latency with FIFO empty and FSM idle:
  - Write sampled at edge N → count=1 after edge N.
  - Pop at edge N+1 → `tx_o` low after edge N+1.
- `busy_o` and `full_o` follow count and FSM state with no extra delay; `full_o` is valid in the cycle after the filling push.
- Back-to-back frames have no idle gap: the stop bit is followed immediately by the next start bit.
- Reset asserted mid-frame:
  - At the next edge, `tx_o` returns to 1, the FIFO is flushed, and the FSM goes to IDLE.
  - The truncated frame is not resumed.
- Simultaneous push to a full FIFO and pop: the push is accepted and count stays at DEPTH.
- Read and write to STATUS in the same cycle: the read returns the pre-write value.

## Structure
- Constants in the shared `defines.v`:
  - `UART_ADDR`.
  - Register offsets `UART_TXDATA`, `UART_STATUS`, `UART_DIV`.
  - STATUS bit positions.
  - FSM state encodings (2-bit).
- One sub-module, `sync_fifo`:
  - Parameterized width and depth, with push/pop/full/empty/count.
  - Same-cycle push and pop when full allowed.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.
- `uart_tx_buf` holds the address decode, DIV/overflow registers, FSM, baud counter and shift register.

## Test plan
- Reset, then write DIV=4 and TXDATA=0x32 → `tx_o` low from edge N+1; line then carries bits 0,1,0,0,1,1,0,0 for 4 cycles each, then high; total 40 cycles; `busy_o` falls after the stop bit.
- Write 10 bytes "2023310655" (0x32,0x30,0x32,0x33,0x33,0x31,0x30,0x36,0x35,0x35) back-to-back, DIV=4 → 400 contiguous cycles of frames, no idle high gap between the stop bit and the next start bit, bytes received in order.
- Write 17 bytes into the 16-deep FIFO while the first frame is in flight:
  - `full_o` asserts once count reaches 16.
  - Any further write is dropped and STATUS bit3 = 1.
  - Writing STATUS=0x8 clears overflow.
- Write DIV=1 → read back 2. Write DIV=8 mid-frame → current frame finishes at the old rate; the next frame uses 8 cycles per bit.
- Assert `rst`=0 during DATA bit 3 → next edge: `tx_o`=1, STATUS reads empty=1 with count 0, DIV back to the default.
- Read unmapped offset 0xC and TXDATA → `rdata_o`=0; a write to 0xC changes nothing.

Source files
------------

// File: rtl/uart_tx_buf_pkg.sv
// uart_tx_buf_pkg: register map, STATUS bit positions and FSM encodings shared by the UART TX buffer
package uart_tx_buf_pkg;

    localparam logic [31:0] UART_ADDR   = 32'h3000_0000;

    localparam logic [31:0] UART_TXDATA = 32'h0;
    localparam logic [31:0] UART_STATUS = 32'h4;
    localparam logic [31:0] UART_DIV    = 32'h8;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_CNT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_tx_buf_sync_fifo.sv
// uart_tx_buf_sync_fifo: synchronous FIFO that accepts a push while full when a pop happens in the same cycle
module uart_tx_buf_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];

    // storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: memory-mapped 8N1 UART transmitter with a TX FIFO, sticky overflow and programmable divisor
module uart_tx_buf
    import uart_tx_buf_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = UART_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raddr_i,
    output logic [31:0] rdata_o,
    output logic        full_o,
    output logic        busy_o,
    output logic        tx_o
);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);

    state_t          state;
    logic [15:0]     div, cur_div, cnt;
    logic [7:0]      shift, fifo_dout;
    logic [2:0]      bit_idx;
    logic [CW-1:0]   count;
    logic [31:0]     status;
    logic            ovf, empty, pop, push_req, wr_status, wr_div, cnt_last;
    logic            unused_wdata;

    assign push_req     = we_i && waddr_i == BASE_ADDR + UART_TXDATA;
    assign wr_status    = we_i && waddr_i == BASE_ADDR + UART_STATUS;
    assign wr_div       = we_i && waddr_i == BASE_ADDR + UART_DIV;
    assign cnt_last     = cnt == cur_div - 16'd1;
    assign pop          = !empty && (state == ST_IDLE || (state == ST_STOP && cnt_last));
    assign busy_o       = !empty || state != ST_IDLE;
    assign unused_wdata = ^wdata_i[31:16];

    uart_tx_buf_sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (wdata_i[7:0]),
        .dout  (fifo_dout),
        .full  (full_o),
        .empty (empty),
        .count (count)
    );

    // STATUS word assembled from live FIFO/FSM state and the sticky overflow flag
    always_comb begin
        status                   = '0;
        status[STAT_BUSY]        = busy_o;
        status[STAT_FULL]        = full_o;
        status[STAT_EMPTY]       = empty;
        status[STAT_OVF]         = ovf;
        status[STAT_CNT +: CW]   = count;
    end

    // read mux; TXDATA and unmapped addresses read as zero
    always_comb begin
        rdata_o = raddr_i == BASE_ADDR + UART_STATUS ? status :
                  raddr_i == BASE_ADDR + UART_DIV    ? {16'h0, div} : 32'h0;
    end

    // divisor register (clamped to 2) and sticky overflow; setting wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= DIV_RST;
            ovf <= 1'b0;
        end else begin
            if (wr_div) div <= wdata_i[15:0] < 16'd2 ? 16'd2 : wdata_i[15:0];
            ovf <= (push_req && full_o && !pop) || (ovf && !(wr_status && wdata_i[STAT_OVF]));
        end
    end

    // frame FSM; the divisor is latched per frame so DIV writes only affect the next start bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            tx_o    <= 1'b1;
            cnt     <= '0;
            cur_div <= DIV_RST;
            shift   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: if (pop) begin
                    state   <= ST_START;
                    tx_o    <= 1'b0;
                    cnt     <= '0;
                    shift   <= fifo_dout;
                    cur_div <= div;
                end
                ST_START: if (cnt_last) begin
                    state   <= ST_DATA;
                    tx_o    <= shift[0];
                    cnt     <= '0;
                    bit_idx <= '0;
                end else cnt <= cnt + 16'd1;
                ST_DATA: if (cnt_last) begin
                    cnt <= '0;
                    if (bit_idx == 3'd7) begin
                        state <= ST_STOP;
                        tx_o  <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        shift   <= shift >> 1;
                        tx_o    <= shift[1];
                    end
                end else cnt <= cnt + 16'd1;
                ST_STOP: if (cnt_last) begin
                    cnt  <= '0;
                    tx_o <= !pop;
                    if (pop) begin
                        state   <= ST_START;
                        shift   <= fifo_dout;
                        cur_div <= div;
                    end else state <= ST_IDLE;
                end else cnt <= cnt + 16'd1;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
